// File: rtl/vend_pkg.sv
// +------------------------------------------------------------------+
// | vend_pkg                                                         |
// | Coin type and default front-end constants shared with vend FSM.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

    typedef enum logic {
        COIN_NICKEL = 1'b0,
        COIN_DIME   = 1'b1
    } coin_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

`default_nettype wire

// File: rtl/coin_debounce.sv
// +------------------------------------------------------------------+
// | coin_debounce                                                    |
// | Synchronizer chain plus persistence counter for one raw line.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module coin_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [7:0] c_cnt_last = 8'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [7:0]             r_cnt;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_level = r_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // The level flips on the edge where the mismatch run reaches its limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_sync == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_level <= w_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// +------------------------------------------------------------------+
// | coin_acceptor                                                    |
// | Debounced coin front end with a 2-deep credit FIFO to vend FSM.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module coin_acceptor
    import vend_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_n,
    input  logic       raw_d,
    input  logic       inhibit,
    output logic       n,
    output logic       d,
    output logic       coin_reject,
    output logic [1:0] pending
);

    logic       w_level_n;
    logic       w_level_d;
    logic       r_level_n_q;
    logic       r_level_d_q;
    logic       r_evt_n;
    logic       r_evt_d;
    coin_t      r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       r_n;
    logic       r_d;
    logic       r_reject;

    logic       w_pop;
    logic [1:0] w_free;
    logic [1:0] w_push_cnt;
    coin_t      w_wdata0;
    coin_t      w_wdata1;
    logic       w_drop;
    coin_t      w_head;

    coin_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_n (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (raw_n),
        .o_level (w_level_n)
    );

    coin_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_d (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (raw_d),
        .o_level (w_level_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level_n_q <= 1'b0;
            r_level_d_q <= 1'b0;
            r_evt_n     <= 1'b0;
            r_evt_d     <= 1'b0;
        end else begin
            r_level_n_q <= w_level_n;
            r_level_d_q <= w_level_d;
            r_evt_n     <= w_level_n & ~r_level_n_q;
            r_evt_d     <= w_level_d & ~r_level_d_q;
        end
    end

    assign w_head = r_mem[r_rptr];
    assign w_pop  = !inhibit && (r_count != 2'd0);
    assign w_free = 2'd2 - r_count + {1'b0, w_pop};

    // Dime is offered first so it lands ahead of a same-cycle nickel.
    always_comb begin
        w_push_cnt = 2'd0;
        w_wdata0   = COIN_NICKEL;
        w_wdata1   = COIN_NICKEL;
        w_drop     = 1'b0;
        if (r_evt_d) begin
            if (!inhibit && (w_free > w_push_cnt)) begin
                w_wdata0   = COIN_DIME;
                w_push_cnt = w_push_cnt + 2'd1;
            end else begin
                w_drop = 1'b1;
            end
        end
        if (r_evt_n) begin
            if (!inhibit && (w_free > w_push_cnt)) begin
                if (w_push_cnt == 2'd0) begin
                    w_wdata0 = COIN_NICKEL;
                end else begin
                    w_wdata1 = COIN_NICKEL;
                end
                w_push_cnt = w_push_cnt + 2'd1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= COIN_NICKEL;
            r_mem[1] <= COIN_NICKEL;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_n      <= 1'b0;
            r_d      <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            if (w_push_cnt != 2'd0) begin
                r_mem[r_wptr] <= w_wdata0;
            end
            if (w_push_cnt == 2'd2) begin
                r_mem[~r_wptr] <= w_wdata1;
            end
            r_wptr   <= r_wptr ^ w_push_cnt[0];
            r_rptr   <= r_rptr ^ w_pop;
            r_count  <= r_count + w_push_cnt - {1'b0, w_pop};
            r_n      <= w_pop && (w_head == COIN_NICKEL);
            r_d      <= w_pop && (w_head == COIN_DIME);
            r_reject <= w_drop;
        end
    end

    assign n           = r_n;
    assign d           = r_d;
    assign coin_reject = r_reject;
    assign pending     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// +------------------------------------------------------------------+
// | tb_coin_acceptor                                                 |
// | Scoreboard bench with a rule-level reference model.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_coin_acceptor;
    import vend_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       raw_n;
    logic       raw_d;
    logic       inhibit;
    logic       n;
    logic       d;
    logic       coin_reject;
    logic [1:0] pending;

    coin_acceptor #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw_n       (raw_n),
        .raw_d       (raw_d),
        .inhibit     (inhibit),
        .n           (n),
        .d           (d),
        .coin_reject (coin_reject),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int       cyc;
        logic [2:0] v;   // {coin_reject, d, n}
    } exp_t;

    exp_t  exp_q [$];
    coin_t mq [$];
    bit    hist_n [MAXC];
    bit    hist_d [MAXC];
    int    base = 0;
    bit    lvl_n = 0, lvl_d = 0, rose_n = 0, rose_d = 0, ev_n = 0, ev_d = 0;
    int    exp_pending = 0;

    int n_cnt = 0, d_cnt = 0, rej_cnt = 0, last_n = -1, last_d = -1;

    // Index of the most recent rising clock edge (rising edges at 5, 15, ...).
    function automatic int edge_idx();
        return int'(($time - 64'd5) / 64'd10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Synchronized level seen after edge k: the raw value sampled SYNC-1 edges earlier.
    function automatic bit sync_val(input bit is_d, input int k);
        int j;
        j = k - SYNC + 1;
        if (j < base || j < 0 || j >= MAXC) return 1'b0;
        return is_d ? hist_d[j] : hist_n[j];
    endfunction

    // A level is accepted when the DEB synchronized values before edge k all differ from it.
    function automatic bit flips(input bit is_d, input int k, input bit lvl);
        for (int j = k - DEB; j <= k - 1; j++) begin
            if (sync_val(is_d, j) == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: debounce rule, rising-edge events, 2-slot FIFO queue, inhibit.
    always @(posedge clk or negedge reset_n) begin
        int         e;
        int         free;
        logic [2:0] v;
        coin_t      head;
        if (!reset_n) begin
            mq.delete();
            exp_q.delete();
            lvl_n = 0; lvl_d = 0; rose_n = 0; rose_d = 0; ev_n = 0; ev_d = 0;
            exp_pending = 0;
            base = ($time < 5) ? 0 : edge_idx() + 1;
        end else begin
            e = edge_idx();
            if (e < MAXC) begin
                hist_n[e] = raw_n;
                hist_d[e] = raw_d;
            end
            v = 3'b000;
            if (!inhibit && mq.size() > 0) begin
                head = mq.pop_front();
                v[0] = (head == COIN_NICKEL);
                v[1] = (head == COIN_DIME);
            end
            free = 2 - mq.size();
            if (ev_d) begin
                if (!inhibit && free > 0) begin mq.push_back(COIN_DIME); free--; end
                else v[2] = 1'b1;
            end
            if (ev_n) begin
                if (!inhibit && free > 0) begin mq.push_back(COIN_NICKEL); free--; end
                else v[2] = 1'b1;
            end
            ev_n = rose_n;
            ev_d = rose_d;
            rose_n = 0;
            rose_d = 0;
            if (flips(1'b0, e, lvl_n)) begin rose_n = !lvl_n; lvl_n = !lvl_n; end
            if (flips(1'b1, e, lvl_d)) begin rose_d = !lvl_d; lvl_d = !lvl_d; end
            exp_pending = mq.size();
            if (v != 3'b000) exp_q.push_back('{cyc: e, v: v});
        end
    end

    // Monitor: compare every presented pulse against the scoreboard head.
    always @(negedge clk) begin
        int         cur;
        logic [2:0] act;
        exp_t       it;
        cur = edge_idx();
        act = {coin_reject, d, n};
        chk("pending", int'(pending), exp_pending);
        chk("n_and_d_exclusive", int'(n && d), 0);
        if (n) begin n_cnt++; last_n = cur; end
        if (d) begin d_cnt++; last_d = cur; end
        if (coin_reject) rej_cnt++;
        if (act != 3'b000) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected edge=%0d actual=%b required=none", cur, act);
            end else begin
                it = exp_q.pop_front();
                if (it.cyc != cur || it.v != act) begin
                    failures++;
                    $display("FAIL scoreboard_pulse edge=%0d actual=%b required=%b@%0d", cur, act, it.v, it.cyc);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cur) begin
            it = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL scoreboard_missing edge=%0d actual=%b required=%b", it.cyc, act, it.v);
        end
    end

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int t0, n0, d0, r0, len, gap;
        bit nk, dm;
        reset_n = 1'b0; raw_n = 1'b0; raw_d = 1'b0; inhibit = 1'b0;
        idle(3);
        chk("reset_n_out", int'(n), 0);
        chk("reset_d_out", int'(d), 0);
        chk("reset_reject", int'(coin_reject), 0);
        chk("reset_pending", int'(pending), 0);
        reset_n = 1'b1;
        idle(3);

        // Single nickel: one pulse, fixed latency.
        n0 = n_cnt;
        @(negedge clk); raw_n = 1'b1; t0 = edge_idx() + 1;
        idle(10); raw_n = 1'b0;
        idle(12);
        chk("nickel_count", n_cnt - n0, 1);
        chk("nickel_latency", last_n - t0, SYNC + DEB + 2);
        chk("nickel_pending_end", int'(pending), 0);

        // Short dime pulse and chatter: filtered out.
        d0 = d_cnt; r0 = rej_cnt;
        @(negedge clk); raw_d = 1'b1;
        idle(3); raw_d = 1'b0;
        idle(10);
        for (int i = 0; i < 20; i++) begin
            raw_d = ~raw_d;
            @(negedge clk);
        end
        raw_d = 1'b0;
        idle(12);
        chk("glitch_d_count", d_cnt - d0, 0);
        chk("glitch_reject_count", rej_cnt - r0, 0);

        // Simultaneous coins: dime then nickel, pending 2->1->0.
        @(negedge clk); raw_n = 1'b1; raw_d = 1'b1; t0 = edge_idx() + 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 8)  chk("both_pending_2", int'(pending), 2);
            if (i == 9)  chk("both_pending_1", int'(pending), 1);
            if (i == 10) begin chk("both_pending_0", int'(pending), 0); raw_n = 1'b0; raw_d = 1'b0; end
        end
        idle(4);
        chk("both_d_latency", last_d - t0, SYNC + DEB + 2);
        chk("both_n_latency", last_n - t0, SYNC + DEB + 3);

        // Inhibited nickel is rejected.
        n0 = n_cnt; r0 = rej_cnt;
        inhibit = 1'b1;
        @(negedge clk); raw_n = 1'b1;
        idle(10); raw_n = 1'b0;
        idle(12);
        chk("inhibit_reject", rej_cnt - r0, 1);
        chk("inhibit_no_n", n_cnt - n0, 0);
        chk("inhibit_pending", int'(pending), 0);
        inhibit = 1'b0;
        idle(3);

        // Two queued, third rejected while held, then released in FIFO order.
        n0 = n_cnt; d0 = d_cnt; r0 = rej_cnt;
        @(negedge clk); raw_n = 1'b1; raw_d = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 8) inhibit = 1'b1;
        end
        raw_n = 1'b0; raw_d = 1'b0;
        idle(6);
        @(negedge clk); raw_n = 1'b1;
        idle(10); raw_n = 1'b0;
        idle(12);
        chk("full_pending_held", int'(pending), 2);
        chk("full_reject", rej_cnt - r0, 1);
        chk("full_no_issue", (n_cnt - n0) + (d_cnt - d0), 0);
        inhibit = 1'b0; t0 = edge_idx() + 1;
        idle(4);
        chk("release_d_first", last_d, t0);
        chk("release_n_second", last_n, t0 + 1);

        // Asynchronous reset with one entry held.
        n0 = n_cnt;
        @(negedge clk); raw_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 8) inhibit = 1'b1;
        end
        raw_n = 1'b0;
        chk("held_pending_1", int'(pending), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pending", int'(pending), 0);
        chk("async_n", int'(n), 0);
        chk("async_d", int'(d), 0);
        idle(2);
        reset_n = 1'b1; inhibit = 1'b0;
        idle(15);
        chk("reset_lost_coin", n_cnt - n0, 0);

        // Randomized traffic including occasional resets and inhibit windows.
        for (int k = 0; k < 70; k++) begin
            nk  = 1'($urandom_range(0, 1));
            dm  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            gap = $urandom_range(0, 12);
            @(negedge clk);
            inhibit = ($urandom_range(0, 4) == 0);
            raw_n = nk; raw_d = dm;
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 9) == 0) inhibit = ~inhibit;
            end
            if ($urandom_range(0, 14) == 0) begin
                #3 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            raw_n = 1'b0; raw_d = 1'b0;
            idle(gap);
        end
        inhibit = 1'b0;
        idle(25);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
